// File: rtl/adder_rr_scheduler_if.sv
// Bundle between the requesters, the round-robin scheduler and the shared 4-bit adder.
// The scheduler takes the slave view. The requesters and the adder take the master view.
interface adder_rr_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ci;

    logic [3:0]         add_a;
    logic [3:0]         add_b;
    logic               add_ci;
    logic [3:0]         add_s;
    logic               add_co;

    logic [N_REQ-1:0]   rsp_valid;
    logic [3:0]         rsp_s;
    logic               rsp_co;

    modport slave (
        input  req_valid, req_a, req_b, req_ci, add_s, add_co,
        output req_ready, add_a, add_b, add_ci, rsp_valid, rsp_s, rsp_co
    );

    modport master (
        output req_valid, req_a, req_b, req_ci, add_s, add_co,
        input  req_ready, add_a, add_b, add_ci, rsp_valid, rsp_s, rsp_co
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one LAT-cycle pipelined 4-bit adder between N_REQ requesters.
// A tag pipe runs alongside the adder and routes each result back to the requester that issued it.
module adder_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int LAT   = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    adder_rr_scheduler_if.slave     bus,
    output logic                    busy,
    output logic [CNTW-1:0]         done_cnt
);

    logic [IDW-1:0]   r_ptr;
    logic             r_tag_v  [LAT];
    logic [IDW-1:0]   r_tag_id [LAT];
    logic [CNTW-1:0]  r_done_cnt;

    logic             w_grant_found;
    logic [IDW-1:0]   w_grant_idx;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_rsp_valid;
    logic             w_inflight;
    logic [IDW+1:0]   w_lane_base;

    // Search order starts at the pointer and wraps. The search is gated by rstn so that nothing is granted while in reset.
    always_comb begin
        int          j;
        logic [IDW-1:0] cand;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        j             = 0;
        cand          = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = IDW'(j);
            if (!w_grant_found && bus.req_valid[cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = cand;
            end
        end
        if (!en || !rstn) begin
            w_grant_found = 1'b0;
            w_grant_idx   = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign w_ready[gi]     = w_grant_found && (w_grant_idx == IDW'(gi));
            assign w_rsp_valid[gi] = r_tag_v[LAT-1] && (r_tag_id[LAT-1] == IDW'(gi));
        end
    endgenerate

    assign bus.req_ready = w_ready;

    // Operands are held at zero when there is no grant. The adder result for that slot is never tagged.
    assign w_lane_base = {w_grant_idx, 2'b00};
    assign bus.add_a   = w_grant_found ? bus.req_a[w_lane_base +: 4] : 4'h0;
    assign bus.add_b   = w_grant_found ? bus.req_b[w_lane_base +: 4] : 4'h0;
    assign bus.add_ci  = w_grant_found ? bus.req_ci[w_grant_idx]     : 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_grant_found) begin
            if (w_grant_idx == IDW'(N_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_idx + 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        r_tag_v[gi]  <= 1'b0;
                        r_tag_id[gi] <= '0;
                    end else begin
                        r_tag_v[gi]  <= w_grant_found;
                        r_tag_id[gi] <= w_grant_idx;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        r_tag_v[gi]  <= 1'b0;
                        r_tag_id[gi] <= '0;
                    end else begin
                        r_tag_v[gi]  <= r_tag_v[gi-1];
                        r_tag_id[gi] <= r_tag_id[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_inflight = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            w_inflight = w_inflight | r_tag_v[k];
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_s     = bus.add_s;
    assign bus.rsp_co    = bus.add_co;
    assign busy          = (|w_ready) | w_inflight;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done_cnt <= '0;
        end else if ((|w_rsp_valid) && (r_done_cnt != {CNTW{1'b1}})) begin
            r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    assign done_cnt = r_done_cnt;

    // An id width too small for N_REQ or an empty tag pipe would silently misroute results.
    always_ff @(posedge clk) begin
        assert (LAT >= 1 && N_REQ >= 2 && N_REQ <= (1 << IDW))
            else $error("adder_rr_scheduler: invalid configuration LAT=%0d N_REQ=%0d IDW=%0d", LAT, N_REQ, IDW);
    end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Shares one 4-bit pipelined adder (4-cycle latency, one operation accepted per cycle) between N_REQ requesters.
- Round-robin arbitration selects one requester per cycle and drives its operands into the adder.
- A tag pipeline matched to the adder latency follows each operation, so every result returns to the requester that issued it.
- Sits between the requester ports and the shared adder instance; also keeps a completion counter for software and debug visibility.

Parameters:
N_REQ, 4, number of requesters (2..8)
LAT, 4, adder latency in clock edges from operand capture to valid sum/carry; must equal the adder instance latency
IDW, 2, requester index width, equals clog2(N_REQ)
CNTW, 16, width of the completion counter

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
en  in  1  issue enable; when low no new grants are made, in-flight operations still drain
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  one-hot grant; handshake on req_valid[i] & req_ready[i] at rising edge
req_a  in  4*N_REQ  operand A, requester i at [4i+3:4i]
req_b  in  4*N_REQ  operand B, same packing
req_ci  in  N_REQ  carry-in per requester
add_a  out  4  operand A to shared adder
add_b  out  4  operand B to shared adder
add_ci  out  1  carry-in to shared adder
add_s  in  4  adder sum
add_co  in  1  adder carry-out
rsp_valid  out  N_REQ  one-hot, one-cycle result-valid pulse
rsp_s  out  4  result sum, valid while any rsp_valid bit is high
rsp_co  out  1  result carry, valid while any rsp_valid bit is high
busy  out  1  high if a grant is active or any operation is in flight
done_cnt  out  CNTW  completed operations, saturating

Behaviour:
- Reset: while rstn is low:
  - req_ready=0, rsp_valid=0, busy=0, done_cnt=0.
  - Round-robin pointer ptr=0.
  - All tag-pipe valid bits cleared.
  - add_a, add_b and add_ci are 0 while rstn is low.
- Arbitration (combinational):
  - If en=1, grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N_REQ.
  - req_ready is the one-hot grant, or 0 when en=0 or no request is valid.
  - req_ready may depend on req_valid. A requester must not drop req_valid before its handshake.
- Pointer update:
  - On a handshake with index g, ptr <= (g+1) mod N_REQ.
  - With no handshake, ptr holds.
- Operand drive (combinational):
  - add_a/add_b/add_ci come from the granted requester.
  - With no grant they are 0, so the adder computes 0+0+0 and that output is ignored.
  - The adder captures operands on the same edge as the handshake.
- Tag pipe: LAT entries of {v, id[IDW-1:0]}.
  - Each edge: tag[0] <= {handshake, g}; tag[i] <= tag[i-1].
- Response (combinational from tag[LAT-1]):
  - rsp_valid = tag[LAT-1].v ? onehot(tag[LAT-1].id) : 0.
  - rsp_s = add_s, rsp_co = add_co.
  - Latency: handshake at edge k -> rsp_valid high during the cycle after edge k+LAT-1 (LAT cycles).
  - No response backpressure; requesters must accept the result in that cycle.
- Throughput: one issue per cycle. Back-to-back grants, including to the same requester when it is the only one valid, give back-to-back responses with no bubbles.
- busy = |req_ready | any tag[i].v.
- done_cnt increments by 1 on each cycle with rsp_valid != 0 and saturates at all-ones.
- en=0 mid-stream: no new issues; the LAT-1 outstanding results still complete; busy falls after the last response.
- Reset mid-operation: the adder and this block share rstn. In-flight operations are discarded, with no response pulses after reset is released.
- Invalid configuration: LAT<1 or N_REQ>2^IDW is a configuration error; the block asserts in simulation.

Test Plan:
- Single op: req 0 sends a=4'h9, b=4'h8, ci=1 at edge k -> rsp_valid=4'b0001 in the cycle after edge k+3, rsp_s=4'h2, rsp_co=1, done_cnt=1.
- Full contention: all 4 requesters hold req_valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 with one grant per cycle. Responses return in the same order, each with its own requester's sum, starting LAT cycles later.
- Pointer skip: ptr=1, only req 0 and req 2 valid -> grant 2 first, then 0, then 2 again if it is still valid.
- Pause: issue 3 ops back-to-back, then set en=0 for 6 cycles with requests pending -> req_ready=0 throughout; 3 responses still arrive; busy=0 once they drain; issue resumes from the saved ptr.
- Reset in flight: issue 2 ops, pulse rstn low for 1 cycle before either result -> no rsp_valid pulses, done_cnt=0, ptr=0.
- Saturation: with CNTW=4, complete 20 ops -> done_cnt stays at 4'hF.
